// File: rtl/cues_split_sync.sv
// rtl/cues_split_sync.sv - clocked token splitter: one SEND/ACK input channel steered to branch A or B
//
// Ports:
//   CLK       system clock, all state updates on the rising edge
//   RESETN    asynchronous active-low reset
//   SENDIN    upstream request (asynchronous, synchronized internally)
//   ACKOUT    acknowledge to upstream
//   SELB      steering select when ALTERNATE=0 (1 = branch B), synchronous to CLK
//   SENDOUTA  request to branch A
//   SENDOUTB  request to branch B
//   ACKINA    acknowledge from branch A (asynchronous, synchronized internally)
//   ACKINB    acknowledge from branch B (asynchronous, synchronized internally)
//   CPA/CPB   one-cycle pulse per token delivered to A / B
//   AEBOUT    high while delivered-token counts of A and B are equal
module cues_split_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int ALTERNATE   = 1
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic SENDIN,
    output logic ACKOUT,
    input  logic SELB,
    output logic SENDOUTA,
    output logic SENDOUTB,
    input  logic ACKINA,
    input  logic ACKINB,
    output logic CPA,
    output logic CPB,
    output logic AEBOUT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_RTZ  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_send;
    logic [SYNC_STAGES-1:0] sync_acka;
    logic [SYNC_STAGES-1:0] sync_ackb;

    logic sendin_s;
    logic ackina_s;
    logic ackinb_s;

    logic [1:0]       state;
    logic             tgt;      // latched target: 0 = A, 1 = B
    logic             toggle;   // round-robin pointer, A goes first
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    logic next_tgt;
    logic ack_t_s;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_send <= '0;
            sync_acka <= '0;
            sync_ackb <= '0;
        end else begin
            sync_send <= {sync_send[SYNC_STAGES-2:0], SENDIN};
            sync_acka <= {sync_acka[SYNC_STAGES-2:0], ACKINA};
            sync_ackb <= {sync_ackb[SYNC_STAGES-2:0], ACKINB};
        end
    end

    assign sendin_s = sync_send[SYNC_STAGES-1];
    assign ackina_s = sync_acka[SYNC_STAGES-1];
    assign ackinb_s = sync_ackb[SYNC_STAGES-1];

    assign next_tgt = (ALTERNATE != 0) ? toggle : SELB;
    // Only the target branch acknowledge matters once a token is in flight.
    assign ack_t_s  = tgt ? ackinb_s : ackina_s;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= ST_IDLE;
            tgt      <= 1'b0;
            toggle   <= 1'b0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            ACKOUT   <= 1'b0;
            SENDOUTA <= 1'b0;
            SENDOUTB <= 1'b0;
            CPA      <= 1'b0;
            CPB      <= 1'b0;
            AEBOUT   <= 1'b1;
        end else begin
            CPA    <= 1'b0;
            CPB    <= 1'b0;
            // Lags any counter change by one cycle.
            AEBOUT <= (cnt_a == cnt_b);
            case (state)
                ST_IDLE: begin
                    // A still-high acknowledge on either branch blocks acceptance.
                    if (sendin_s && !ackina_s && !ackinb_s) begin
                        tgt      <= next_tgt;
                        SENDOUTA <= ~next_tgt;
                        SENDOUTB <= next_tgt;
                        toggle   <= ~toggle;
                        state    <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (ack_t_s) begin
                        SENDOUTA <= 1'b0;
                        SENDOUTB <= 1'b0;
                        ACKOUT   <= 1'b1;
                        if (tgt) begin
                            CPB   <= 1'b1;
                            cnt_b <= cnt_b + CNT_ONE;
                        end else begin
                            CPA   <= 1'b1;
                            cnt_a <= cnt_a + CNT_ONE;
                        end
                        state <= ST_RTZ;
                    end
                end
                ST_RTZ: begin
                    if (!sendin_s) begin
                        ACKOUT <= 1'b0;
                        state  <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!ack_t_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cues_split_sync.sv
// tb/tb_cues_split_sync.sv - directed self-checking bench for cues_split_sync
module tb_cues_split_sync;

    logic clk;
    logic resetn;
    logic sendin [3];
    logic selb   [3];
    logic acka   [3];
    logic ackb   [3];
    logic ackout [3];
    logic so_a   [3];
    logic so_b   [3];
    logic cpa    [3];
    logic cpb    [3];
    logic aeb    [3];

    int checks;
    int errors;
    int cpa_n  [3];
    int cpb_n  [3];
    int both_n [3];

    // 0: alternating, 1: select mode, 2: select mode with 2-bit counters
    cues_split_sync #(.SYNC_STAGES(2), .CNT_W(8), .ALTERNATE(1)) u_alt (
        .CLK(clk), .RESETN(resetn), .SENDIN(sendin[0]), .ACKOUT(ackout[0]),
        .SELB(selb[0]), .SENDOUTA(so_a[0]), .SENDOUTB(so_b[0]),
        .ACKINA(acka[0]), .ACKINB(ackb[0]), .CPA(cpa[0]), .CPB(cpb[0]),
        .AEBOUT(aeb[0]));

    cues_split_sync #(.SYNC_STAGES(2), .CNT_W(8), .ALTERNATE(0)) u_sel (
        .CLK(clk), .RESETN(resetn), .SENDIN(sendin[1]), .ACKOUT(ackout[1]),
        .SELB(selb[1]), .SENDOUTA(so_a[1]), .SENDOUTB(so_b[1]),
        .ACKINA(acka[1]), .ACKINB(ackb[1]), .CPA(cpa[1]), .CPB(cpb[1]),
        .AEBOUT(aeb[1]));

    cues_split_sync #(.SYNC_STAGES(2), .CNT_W(2), .ALTERNATE(0)) u_wrap (
        .CLK(clk), .RESETN(resetn), .SENDIN(sendin[2]), .ACKOUT(ackout[2]),
        .SELB(selb[2]), .SENDOUTA(so_a[2]), .SENDOUTB(so_b[2]),
        .ACKINA(acka[2]), .ACKINB(ackb[2]), .CPA(cpa[2]), .CPB(cpb[2]),
        .AEBOUT(aeb[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cpa[k] === 1'b1) cpa_n[k] <= cpa_n[k] + 1;
            if (cpb[k] === 1'b1) cpb_n[k] <= cpb_n[k] + 1;
            if (cpa[k] === 1'b1 && cpb[k] === 1'b1) both_n[k] <= both_n[k] + 1;
        end
    end

    // w: 0 SENDOUTA, 1 SENDOUTB, 2 ACKOUT, 3 CPA, 4 CPB, 5 AEBOUT
    function automatic logic outsig(int k, int w);
        case (w)
            0:       return so_a[k];
            1:       return so_b[k];
            2:       return ackout[k];
            3:       return cpa[k];
            4:       return cpb[k];
            default: return aeb[k];
        endcase
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges (sampled 1ns after each) until the output reaches lvl.
    task automatic wait_for(int k, int w, logic lvl, int maxc, output int lat);
        lat = 0;
        while (outsig(k, w) !== lvl && lat < maxc) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One full 4-phase handshake on instance k, expected to land on branch tb (0=A, 1=B).
    task automatic token(int k, int tb, string tag);
        int lat;
        @(negedge clk);
        sendin[k] = 1'b1;
        wait_for(k, tb, 1'b1, 20, lat);
        chk({tag, "_req_lat"}, lat, 3);
        chk({tag, "_other_req"}, int'(outsig(k, 1 - tb)), 0);
        @(negedge clk);
        if (tb == 1) ackb[k] = 1'b1; else acka[k] = 1'b1;
        wait_for(k, 2, 1'b1, 20, lat);
        chk({tag, "_ack_lat"}, lat, 3);
        chk({tag, "_cp"}, int'(outsig(k, 3 + tb)), 1);
        chk({tag, "_req_drop"}, int'(outsig(k, tb)), 0);
        @(negedge clk);
        sendin[k] = 1'b0;
        wait_for(k, 2, 1'b0, 20, lat);
        chk({tag, "_rtz_lat"}, lat, 3);
        @(negedge clk);
        acka[k] = 1'b0;
        ackb[k] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int bad;
        checks = 0;
        errors = 0;
        for (int k = 0; k < 3; k++) begin
            cpa_n[k] = 0; cpb_n[k] = 0; both_n[k] = 0;
        end

        // Reset with arbitrary inputs
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sendin[k] = 1'b1; selb[k] = 1'b1; acka[k] = 1'b1; ackb[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_outs%0d", k),
                int'({so_a[k], so_b[k], ackout[k], cpa[k], cpb[k]}), 0);
            chk($sformatf("rst_aeb%0d", k), int'(aeb[k]), 1);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sendin[k] = 1'b0; selb[k] = 1'b0; acka[k] = 1'b0; ackb[k] = 1'b0;
        end
        resetn = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++)
                if ({so_a[k], so_b[k], ackout[k], cpa[k], cpb[k], aeb[k]} !== 6'b000001) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Alternation A, B, A, B with AEB 1->0->1->0->1
        chk("alt_aeb0", int'(aeb[0]), 1);
        token(0, 0, "alt1");
        chk("alt_aeb1", int'(aeb[0]), 0);
        token(0, 1, "alt2");
        chk("alt_aeb2", int'(aeb[0]), 1);
        token(0, 0, "alt3");
        chk("alt_aeb3", int'(aeb[0]), 0);
        token(0, 1, "alt4");
        chk("alt_aeb4", int'(aeb[0]), 1);
        chk("alt_cpa_n", cpa_n[0], 2);
        chk("alt_cpb_n", cpb_n[0], 2);

        // Select mode, SELB=1 for three tokens
        selb[1] = 1'b1;
        token(1, 1, "sel1");
        token(1, 1, "sel2");
        token(1, 1, "sel3");
        chk("sel_cntb", int'(u_sel.cnt_b), 3);
        chk("sel_aeb", int'(aeb[1]), 0);
        chk("sel_cpa_n", cpa_n[1], 0);
        chk("sel_cpb_n", cpb_n[1], 3);

        // Wrap with 2-bit counters, four tokens to A
        selb[2] = 1'b0;
        token(2, 0, "wrap1");
        chk("wrap_aeb1", int'(aeb[2]), 0);
        token(2, 0, "wrap2");
        token(2, 0, "wrap3");
        chk("wrap_aeb3", int'(aeb[2]), 0);
        token(2, 0, "wrap4");
        chk("wrap_aeb4", int'(aeb[2]), 1);
        chk("wrap_cnta", int'(u_wrap.cnt_a), 0);

        // Blocking by a high non-target acknowledge (next target is A)
        @(negedge clk);
        ackb[0] = 1'b1;
        sendin[0] = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (so_a[0] !== 1'b0 || so_b[0] !== 1'b0) bad++;
        end
        chk("blk_no_req", bad, 0);
        @(negedge clk);
        ackb[0] = 1'b0;
        wait_for(0, 0, 1'b1, 20, lat);
        chk("blk_release_lat", lat, 3);
        @(negedge clk);
        acka[0] = 1'b1;
        wait_for(0, 2, 1'b1, 20, lat);
        @(negedge clk);
        sendin[0] = 1'b0;
        wait_for(0, 2, 1'b0, 20, lat);
        @(negedge clk);
        acka[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("blk_aeb", int'(aeb[0]), 0);

        // Mid-token reset: toggle now points at B
        @(negedge clk);
        sendin[0] = 1'b1;
        wait_for(0, 1, 1'b1, 20, lat);
        chk("mid_req_b_lat", lat, 3);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_async_drop", int'({so_a[0], so_b[0], ackout[0]}), 0);
        chk("mid_aeb", int'(aeb[0]), 1);
        @(negedge clk);
        resetn = 1'b1;
        wait_for(0, 0, 1'b1, 20, lat);
        chk("mid_new_a_lat", lat, 3);
        chk("mid_new_not_b", int'(so_b[0]), 0);

        for (int k = 0; k < 3; k++)
            chk($sformatf("cp_exclusive%0d", k), both_n[k], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
